// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master bus arbiter: FSM states, owner index,
// timeout read data and the width-padded request bundle used for muxing.
package arbiterPkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        READ_WAIT
    } arbState;

    typedef logic owner_t;

    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEADBEEF;

    // Request fields are padded to the widest supported bus; users cast in/out.
    localparam int unsigned BUS_ADDR_MAX = 64;
    localparam int unsigned BUS_DATA_MAX = 64;
    localparam int unsigned BUS_BWE_MAX  = BUS_DATA_MAX / 8;

    typedef struct packed {
        logic                    read;
        logic                    write;
        logic [BUS_BWE_MAX-1:0]  bwe;
        logic [BUS_ADDR_MAX-1:0] address;
        logic [BUS_DATA_MAX-1:0] dataOut;
    } bus_req_t;

    function automatic logic [1:0] owner_onehot(input owner_t owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arbiter_read_timer.sv
// Clearable, enabled cycle counter; terminal flags the last READ_WAIT cycle
// before a forced read abort.
module read_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master / one-slave bus arbiter with read ownership tracking
// and read timeout. Optional BUS_LOCK_EN adds m0_lock for atomic m0 sequences.
module bus_arbiter
    import arbiterPkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           READ_TIMEOUT = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(TIMEOUT_DATA_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef BUS_LOCK_EN
    input  logic                    m0_lock,
`endif
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [DATA_WIDTH/8-1:0] m0_bwe,
    input  logic [ADDR_WIDTH-1:0]   m0_address,
    input  logic [DATA_WIDTH-1:0]   m0_dataOut,
    output logic                    m0_waitRequest,
    output logic                    m0_readValid,
    output logic [DATA_WIDTH-1:0]   m0_dataIn,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [DATA_WIDTH/8-1:0] m1_bwe,
    input  logic [ADDR_WIDTH-1:0]   m1_address,
    input  logic [DATA_WIDTH-1:0]   m1_dataOut,
    output logic                    m1_waitRequest,
    output logic                    m1_readValid,
    output logic [DATA_WIDTH-1:0]   m1_dataIn,
    output logic                    s_read,
    output logic                    s_write,
    output logic [DATA_WIDTH/8-1:0] s_bwe,
    output logic [ADDR_WIDTH-1:0]   s_address,
    output logic [DATA_WIDTH-1:0]   s_dataOut,
    input  logic                    s_waitRequest,
    input  logic                    s_readValid,
    input  logic [DATA_WIDTH-1:0]   s_dataIn,
    output logic [1:0]              grant,
    output logic                    timeoutError
);

    localparam int unsigned BWE_W = DATA_WIDTH / 8;

    arbState  state_q, state_d;
    owner_t   owner_q, owner_d;
    logic     last_grant_q, last_grant_d;
    bus_req_t req0, req1, sel;
    logic     req0_any, req1_eff;
    logic     timer_clr, timer_en, timer_tc;
    logic     read_done, timed_out, complete;
`ifdef BUS_LOCK_EN
    logic     lock_hold_q, lock_hold_d;
`endif

    read_timer #(.TIMEOUT(READ_TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clr),
        .enable   (timer_en),
        .terminal (timer_tc)
    );

    always_comb begin
        req0 = '{read: m0_read, write: m0_write, bwe: BUS_BWE_MAX'(m0_bwe),
                 address: BUS_ADDR_MAX'(m0_address), dataOut: BUS_DATA_MAX'(m0_dataOut)};
        req1 = '{read: m1_read, write: m1_write, bwe: BUS_BWE_MAX'(m1_bwe),
                 address: BUS_ADDR_MAX'(m1_address), dataOut: BUS_DATA_MAX'(m1_dataOut)};
        sel  = owner_q ? req1 : req0;

        req0_any = m0_read || m0_write;
`ifdef BUS_LOCK_EN
        req1_eff = (m1_read || m1_write) && !lock_hold_q;
`else
        req1_eff = m1_read || m1_write;
`endif

        // Real slave data on the terminal cycle takes priority over the abort.
        read_done = (state_q == READ_WAIT) && (s_readValid || timer_tc);
        timed_out = (state_q == READ_WAIT) && timer_tc && !s_readValid;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        timer_clr    = 1'b0;
        timer_en     = 1'b0;
        complete     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_any && req1_eff) begin
                    owner_d = !last_grant_q;
                end else if (req0_any) begin
                    owner_d = 1'b0;
                end else if (req1_eff) begin
                    owner_d = 1'b1;
                end
                if (req0_any || req1_eff) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!sel.read && !sel.write) begin
                    state_d = IDLE;
                end else if (!s_waitRequest) begin
                    if (sel.read) begin
                        timer_clr = 1'b1;
                        state_d   = READ_WAIT;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            READ_WAIT: begin
                timer_en = 1'b1;
                if (read_done) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            last_grant_d = owner_q;
        end
    end

`ifdef BUS_LOCK_EN
    always_comb begin
        lock_hold_d = m0_lock && (lock_hold_q || (complete && !owner_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_hold_q <= 1'b0;
        end else begin
            lock_hold_q <= lock_hold_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        grant          = (state_q == IDLE) ? 2'b00 : owner_onehot(owner_q);
        s_read         = (state_q == ADDR) && sel.read;
        s_write        = (state_q == ADDR) && sel.write;
        s_bwe          = BWE_W'(sel.bwe);
        s_address      = ADDR_WIDTH'(sel.address);
        s_dataOut      = DATA_WIDTH'(sel.dataOut);

        m0_waitRequest = 1'b1;
        m1_waitRequest = 1'b1;
        if (state_q == ADDR) begin
            if (owner_q) begin
                m1_waitRequest = s_waitRequest;
            end else begin
                m0_waitRequest = s_waitRequest;
            end
        end

        m0_readValid = read_done && !owner_q;
        m1_readValid = read_done && owner_q;
        m0_dataIn    = (timed_out && !owner_q) ? TIMEOUT_DATA : s_dataIn;
        m1_dataIn    = (timed_out && owner_q) ? TIMEOUT_DATA : s_dataIn;
        timeoutError = timed_out;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed master/slave stimulus pushes
// expected slave accepts and read returns; a monitor pops and compares them.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
`ifdef BUS_LOCK_EN
    logic        m0_lock;
`endif
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_bwe, m1_bwe, s_bwe;
    logic [31:0] m0_address, m1_address, m0_dataOut, m1_dataOut;
    logic        m0_waitRequest, m1_waitRequest, m0_readValid, m1_readValid;
    logic [31:0] m0_dataIn, m1_dataIn;
    logic        s_read, s_write, s_waitRequest, s_readValid;
    logic [31:0] s_address, s_dataOut, s_dataIn;
    logic [1:0]  grant;
    logic        timeoutError;

    int checks = 0;
    int failures = 0;

    bus_arbiter #(.READ_TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef BUS_LOCK_EN
        .m0_lock        (m0_lock),
`endif
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_bwe         (m0_bwe),
        .m0_address     (m0_address),
        .m0_dataOut     (m0_dataOut),
        .m0_waitRequest (m0_waitRequest),
        .m0_readValid   (m0_readValid),
        .m0_dataIn      (m0_dataIn),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_bwe         (m1_bwe),
        .m1_address     (m1_address),
        .m1_dataOut     (m1_dataOut),
        .m1_waitRequest (m1_waitRequest),
        .m1_readValid   (m1_readValid),
        .m1_dataIn      (m1_dataIn),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_bwe          (s_bwe),
        .s_address      (s_address),
        .s_dataOut      (s_dataOut),
        .s_waitRequest  (s_waitRequest),
        .s_readValid    (s_readValid),
        .s_dataIn       (s_dataIn),
        .grant          (grant),
        .timeoutError   (timeoutError)
    );

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bwe;
    } txn_t;

    typedef struct {
        bit          rv;
        logic [1:0]  grant;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bwe;
        bit          who;
        bit          tmo;
    } exp_t;

    txn_t q0[$];
    txn_t q1[$];
    exp_t expq[$];

    int          slave_wait = 0;
    int          rv_delay = 0;
    int          wait_cnt = 0;
    int          rv_cnt = 0;
    logic [31:0] rv_data = '0;
    bit          stray_rv = 1'b0;

    task automatic chk_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic txn_t t_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        txn_t t;
        t.rd = 1'b0; t.addr = a; t.data = d; t.bwe = b;
        return t;
    endfunction

    function automatic txn_t t_rd(input logic [31:0] a);
        txn_t t;
        t.rd = 1'b1; t.addr = a; t.data = '0; t.bwe = '0;
        return t;
    endfunction

    task automatic push_acc(input logic [1:0] g, input txn_t t);
        exp_t e;
        e.rv = 1'b0; e.grant = g; e.rd = t.rd; e.addr = t.addr; e.data = t.data;
        e.bwe = t.bwe; e.who = 1'b0; e.tmo = 1'b0;
        expq.push_back(e);
    endtask

    task automatic push_rv(input bit who, input logic [31:0] d, input bit tmo);
        exp_t e;
        e.rv = 1'b1; e.grant = '0; e.rd = 1'b1; e.addr = '0; e.data = d;
        e.bwe = '0; e.who = who; e.tmo = tmo;
        expq.push_back(e);
    endtask

    // Monitor: every slave accept and every master read return pops one entry.
    exp_t me;
    always @(negedge clk) begin
        if (reset) begin
            if ((s_read || s_write) && !s_waitRequest) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL acc_unexpected: grant=%b rd=%b wr=%b addr=%h want none",
                             grant, s_read, s_write, s_address);
                end else begin
                    me = expq.pop_front();
                    if (me.rv || grant !== me.grant || s_read !== me.rd || s_write !== !me.rd ||
                        s_address !== me.addr || s_dataOut !== me.data || s_bwe !== me.bwe ||
                        m0_waitRequest !== (me.grant != 2'b01) ||
                        m1_waitRequest !== (me.grant != 2'b10)) begin
                        failures++;
                        $display("FAIL acc: got grant=%b rd=%b wr=%b addr=%h data=%h bwe=%h wait=%b%b want rv=%b grant=%b rd=%b addr=%h data=%h bwe=%h",
                                 grant, s_read, s_write, s_address, s_dataOut, s_bwe,
                                 m1_waitRequest, m0_waitRequest, me.rv, me.grant, me.rd,
                                 me.addr, me.data, me.bwe);
                    end
                end
            end
            if (m0_readValid || m1_readValid) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL rv_unexpected: rv=%b%b data0=%h data1=%h want none",
                             m1_readValid, m0_readValid, m0_dataIn, m1_dataIn);
                end else begin
                    me = expq.pop_front();
                    if (!me.rv || (m0_readValid && m1_readValid) || m1_readValid !== me.who ||
                        (m1_readValid ? m1_dataIn : m0_dataIn) !== me.data ||
                        timeoutError !== me.tmo) begin
                        failures++;
                        $display("FAIL rv: got rv=%b%b data0=%h data1=%h tmo=%b want rv=%b who=%b data=%h tmo=%b",
                                 m1_readValid, m0_readValid, m0_dataIn, m1_dataIn, timeoutError,
                                 me.rv, me.who, me.data, me.tmo);
                    end
                end
            end
            if (timeoutError && !(m0_readValid || m1_readValid)) begin
                checks++;
                failures++;
                $display("FAIL tmo_alone: got timeoutError=1 without readValid want 0");
            end
        end
    end

    initial begin : drv0
        txn_t t;
        int   n;
        m0_read = 1'b0; m0_write = 1'b0; m0_bwe = '0; m0_address = '0; m0_dataOut = '0;
        forever begin
            @(posedge clk); #1;
            if (q0.size() > 0 && reset) begin
                t = q0.pop_front();
                m0_read = t.rd; m0_write = !t.rd; m0_bwe = t.bwe;
                m0_address = t.addr; m0_dataOut = t.data;
                n = 0;
                do begin @(negedge clk); n++; end while (m0_waitRequest && n < 100);
                if (m0_waitRequest) begin
                    checks++; failures++;
                    $display("FAIL m0_accept_timeout: got waitRequest=1 for %0d cycles want 0", n);
                end
            end else begin
                m0_read = 1'b0; m0_write = 1'b0;
            end
        end
    end

    initial begin : drv1
        txn_t t;
        int   n;
        m1_read = 1'b0; m1_write = 1'b0; m1_bwe = '0; m1_address = '0; m1_dataOut = '0;
        forever begin
            @(posedge clk); #1;
            if (q1.size() > 0 && reset) begin
                t = q1.pop_front();
                m1_read = t.rd; m1_write = !t.rd; m1_bwe = t.bwe;
                m1_address = t.addr; m1_dataOut = t.data;
                n = 0;
                do begin @(negedge clk); n++; end while (m1_waitRequest && n < 100);
                if (m1_waitRequest) begin
                    checks++; failures++;
                    $display("FAIL m1_accept_timeout: got waitRequest=1 for %0d cycles want 0", n);
                end
            end else begin
                m1_read = 1'b0; m1_write = 1'b0;
            end
        end
    end

    // Slave: stalls each strobe slave_wait cycles, returns addr^A5A50000 rv_delay cycles later.
    initial begin : slave
        s_waitRequest = 1'b0; s_readValid = 1'b0; s_dataIn = '0;
        forever begin
            @(posedge clk); #2;
            s_readValid = 1'b0;
            if (stray_rv) begin
                s_readValid = 1'b1; s_dataIn = 32'h5757_5757; stray_rv = 1'b0;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    s_readValid = 1'b1; s_dataIn = rv_data;
                end
            end
            if (s_read || s_write) begin
                if (wait_cnt < slave_wait) begin
                    s_waitRequest = 1'b1; wait_cnt++;
                end else begin
                    s_waitRequest = 1'b0; wait_cnt = 0;
                    if (s_read && rv_delay > 0) begin
                        rv_cnt = rv_delay; rv_data = s_address ^ 32'hA5A5_0000;
                    end
                end
            end else begin
                s_waitRequest = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1'b0;
        rv_cnt = 0; wait_cnt = 0; stray_rv = 1'b0;
        s_readValid = 1'b0; s_waitRequest = 1'b0;
        q0.delete(); q1.delete(); expq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((expq.size() > 0 || q0.size() > 0 || q1.size() > 0) && n < 200) begin
            @(negedge clk); n++;
        end
        chk_eq({name, "_drain"}, 64'(expq.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish by 100us want finish");
        $fatal(1);
    end

    initial begin : main
        logic [6:0] pat;
        int         hold, lat;
        bit         mir, acc;
`ifdef BUS_LOCK_EN
        bit         m1_seen;
        m0_lock = 1'b0;
`endif
        reset = 1'b1;
        #1 reset = 1'b0;
        #10;
        chk_eq("reset_state",
               {s_read, s_write, grant, m0_waitRequest, m1_waitRequest, m0_readValid, m1_readValid, timeoutError},
               9'b0_0_00_1_1_0_0_0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // m0 writes: 1-cycle request latency, then one accept every 2 cycles
        slave_wait = 0; rv_delay = 0;
        push_acc(2'b01, t_wr(32'h100, 32'h1234_5678, 4'hF));
        push_acc(2'b01, t_wr(32'h104, 32'hCAFE_F00D, 4'h3));
        push_acc(2'b01, t_wr(32'h108, 32'h0000_00A5, 4'h1));
        q0.push_back(t_wr(32'h100, 32'h1234_5678, 4'hF));
        q0.push_back(t_wr(32'h104, 32'hCAFE_F00D, 4'h3));
        q0.push_back(t_wr(32'h108, 32'h0000_00A5, 4'h1));
        @(posedge clk); #3;
        pat = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) chk_eq("t1_idle", {s_write, grant, m0_waitRequest}, 4'b0_00_1);
            if (c == 1) chk_eq("t1_grant", {s_write, grant, m0_waitRequest, m1_waitRequest}, 5'b1_01_0_1);
            pat = {pat[5:0], s_write && !s_waitRequest};
        end
        chk_eq("t1_rate", pat, 7'b0101010);
        drain("t1");

        // Both masters read continuously: grants alternate starting with m0
        do_reset();
        rv_delay = 2;
        push_acc(2'b01, t_rd(32'h200)); push_rv(1'b0, 32'hA5A5_0200, 1'b0);
        push_acc(2'b10, t_rd(32'h300)); push_rv(1'b1, 32'hA5A5_0300, 1'b0);
        push_acc(2'b01, t_rd(32'h204)); push_rv(1'b0, 32'hA5A5_0204, 1'b0);
        push_acc(2'b10, t_rd(32'h304)); push_rv(1'b1, 32'hA5A5_0304, 1'b0);
        q0.push_back(t_rd(32'h200)); q0.push_back(t_rd(32'h204));
        q1.push_back(t_rd(32'h300)); q1.push_back(t_rd(32'h304));
        drain("t2");

        // m1 read stalled 3 cycles while m0 waits behind it
        do_reset();
        slave_wait = 3; rv_delay = 1;
        push_acc(2'b10, t_rd(32'h400)); push_rv(1'b1, 32'hA5A5_0400, 1'b0);
        push_acc(2'b01, t_wr(32'h500, 32'h55AA_55AA, 4'hF));
        q1.push_back(t_rd(32'h400));
        @(posedge clk); #3;
        q0.push_back(t_wr(32'h500, 32'h55AA_55AA, 4'hF));
        hold = 0; mir = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_read) begin
                hold++;
                if (!(m1_waitRequest == s_waitRequest && m0_waitRequest && grant == 2'b10)) mir = 1'b0;
                if (!s_waitRequest) break;
            end
        end
        chk_eq("t3_hold", 64'(hold), 64'd4);
        chk_eq("t3_mirror", {63'd0, mir}, 64'd1);
        drain("t3");

        // Silent slave: timeout 4 cycles after accept, stray readValid ignored
        do_reset();
        slave_wait = 0; rv_delay = 0;
        push_acc(2'b01, t_rd(32'h600)); push_rv(1'b0, 32'hDEAD_BEEF, 1'b1);
        q0.push_back(t_rd(32'h600));
        acc = 1'b0; lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (acc) lat++;
            if (acc && (m0_readValid || m1_readValid)) break;
            if (s_read && !s_waitRequest) acc = 1'b1;
        end
        chk_eq("t4_latency", 64'(lat), 64'd4);
        chk_eq("t4_tmo", {timeoutError, m0_readValid, m1_readValid, m0_dataIn}, {3'b110, 32'hDEAD_BEEF});
        stray_rv = 1'b1;
        @(negedge clk);
        chk_eq("t4_stray", {s_readValid, m0_readValid, m1_readValid, timeoutError}, 4'b1000);
        // Slave answers on the terminal cycle: real data, no timeoutError
        rv_delay = 4;
        push_acc(2'b10, t_rd(32'h700)); push_rv(1'b1, 32'hA5A5_0700, 1'b0);
        q1.push_back(t_rd(32'h700));
        drain("t4");

        // Reset during READ_WAIT aborts; next contention goes to m0
        do_reset();
        rv_delay = 0;
        push_acc(2'b01, t_rd(32'hA00));
        q0.push_back(t_rd(32'hA00));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_read && !s_waitRequest) break;
        end
        @(negedge clk);
        chk_eq("t5_rw", {grant, s_read}, 3'b01_0);
        #2 reset = 1'b0; rv_cnt = 0;
        #1 chk_eq("t5_abort", {s_read, s_write, grant, m0_readValid, m1_readValid, timeoutError}, 7'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_eq("t5_empty", 64'(expq.size()), 64'd0);
        push_acc(2'b01, t_wr(32'hB00, 32'h0B0B_0B0B, 4'hF));
        push_acc(2'b10, t_wr(32'hC00, 32'h0C0C_0C0C, 4'hC));
        q0.push_back(t_wr(32'hB00, 32'h0B0B_0B0B, 4'hF));
        q1.push_back(t_wr(32'hC00, 32'h0C0C_0C0C, 4'hC));
        drain("t5");

`ifdef BUS_LOCK_EN
        // m0_lock holds off m1 across two m0 writes
        do_reset();
        m0_lock = 1'b1;
        push_acc(2'b01, t_wr(32'hD00, 32'h1111_1111, 4'hF));
        push_acc(2'b01, t_wr(32'hD04, 32'h2222_2222, 4'hF));
        push_acc(2'b10, t_wr(32'hE00, 32'h3333_3333, 4'hF));
        q0.push_back(t_wr(32'hD00, 32'h1111_1111, 4'hF));
        q0.push_back(t_wr(32'hD04, 32'h2222_2222, 4'hF));
        q1.push_back(t_wr(32'hE00, 32'h3333_3333, 4'hF));
        for (int c = 0; c < 40 && expq.size() > 1; c++) @(negedge clk);
        m1_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (grant == 2'b10) m1_seen = 1'b1;
        end
        chk_eq("lk_hold", {expq.size() == 1, m1_seen}, 2'b10);
        m0_lock = 1'b0;
        drain("lk");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
